// File: rtl/frame_gate_wrap.sv
`default_nettype none
// ============================================================================
// Module   : frame_gate_wrap
// Brief    : Frame gate around a ready/valid pipeline. Optional output-stall
//            watchdog is enabled by defining FRAME_GATE_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module frame_gate_wrap #(
  parameter int IN_W         = 64,
  parameter int OUT_W        = 64,
  parameter int IN_BEATS     = 38400,
  parameter int OUT_BEATS    = 153600,
  parameter int CLEAR_CYCLES = 150,
  parameter int FRAME_CNT_W  = 8,
  parameter int TIMEOUT_CYC  = 4096
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   cfg_continuous,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_W-1:0]        in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_data,
  output logic                   pipe_in_valid,
  input  logic                   pipe_in_ready,
  output logic [IN_W-1:0]        pipe_in_data,
  input  logic                   pipe_out_valid,
  output logic                   pipe_out_ready,
  input  logic [OUT_W-1:0]       pipe_out_data,
  output logic                   pipe_reset,
  output logic                   busy,
  output logic                   frame_done,
  output logic [FRAME_CNT_W-1:0] frames_done,
  output logic [31:0]            tot_in,
  output logic [31:0]            tot_out,
  output logic                   err_timeout
);

  localparam int CIN_W  = (IN_BEATS > 1) ? $clog2(IN_BEATS) : 1;
  localparam int CMAX   = (OUT_BEATS > CLEAR_CYCLES) ? OUT_BEATS : CLEAR_CYCLES;
  localparam int COUT_W = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CIN_W-1:0]  IN_LAST  = CIN_W'(IN_BEATS - 1);
  localparam logic [COUT_W-1:0] OUT_LAST = COUT_W'(OUT_BEATS - 1);
  localparam logic [COUT_W-1:0] CLR_LAST = COUT_W'(CLEAR_CYCLES - 1);

  typedef enum logic [1:0] {IN_IDLE = 2'd0, IN_PASS = 2'd1, IN_WAIT = 2'd2} in_state_t;
  typedef enum logic [1:0] {OUT_IDLE = 2'd0, OUT_PASS = 2'd1, OUT_CLEAR = 2'd2} out_state_t;

  in_state_t               in_st_q, in_st_d;
  out_state_t              out_st_q, out_st_d;
  logic [CIN_W-1:0]        cnt_in_q, cnt_in_d;
  logic [COUT_W-1:0]       cnt_out_q, cnt_out_d;
  logic                    stop_q, stop_d;
  logic [FRAME_CNT_W-1:0]  frames_q, frames_d;
  logic [31:0]             tot_in_q, tot_in_d, tot_out_q, tot_out_d;

  logic w_in_pass, w_out_pass, w_out_clear, w_both_idle, w_start_ok;
  logic w_in_beat, w_out_beat, w_clear_end, w_run_next;
  logic w_timeout_hit, w_count_frame;

  assign w_in_pass   = (in_st_q == IN_PASS);
  assign w_out_pass  = (out_st_q == OUT_PASS);
  assign w_out_clear = (out_st_q == OUT_CLEAR);
  assign w_both_idle = (in_st_q == IN_IDLE) && (out_st_q == OUT_IDLE);
  assign w_start_ok  = start && w_both_idle;
  assign w_in_beat   = w_in_pass && in_valid && pipe_in_ready;
  assign w_out_beat  = w_out_pass && pipe_out_valid && out_ready;
  assign w_clear_end = w_out_clear && (cnt_out_q == CLR_LAST);
  // A stop arriving on the boundary cycle itself still ends the run.
  assign w_run_next  = cfg_continuous && !(stop_q || stop);

  assign pipe_in_data   = in_data;
  assign pipe_in_valid  = w_in_pass && in_valid;
  assign in_ready       = w_in_pass && pipe_in_ready;
  assign out_data       = pipe_out_data;
  assign out_valid      = w_out_pass && pipe_out_valid;
  assign pipe_out_ready = (w_out_pass && out_ready) || w_out_clear;
  assign pipe_reset     = !w_out_pass;
  assign busy           = !w_both_idle;
  assign frame_done     = w_clear_end;
  assign frames_done    = frames_q;
  assign tot_in         = tot_in_q;
  assign tot_out        = tot_out_q;

  always_comb begin
    in_st_d   = in_st_q;
    cnt_in_d  = cnt_in_q;
    out_st_d  = out_st_q;
    cnt_out_d = cnt_out_q;
    frames_d  = frames_q;
    stop_d    = stop ? 1'b1 : (w_both_idle ? 1'b0 : stop_q);
    tot_in_d  = tot_in_q + {31'd0, pipe_in_valid && pipe_in_ready};
    tot_out_d = tot_out_q + {31'd0, pipe_out_valid && pipe_out_ready};

    case (in_st_q)
      IN_IDLE: begin
        if (w_start_ok) begin
          in_st_d  = IN_PASS;
          cnt_in_d = '0;
        end
      end
      IN_PASS: begin
        if (w_timeout_hit) begin
          in_st_d  = IN_WAIT;
          cnt_in_d = '0;
        end else if (w_in_beat) begin
          if (cnt_in_q == IN_LAST) begin
            in_st_d  = IN_WAIT;
            cnt_in_d = '0;
          end else begin
            cnt_in_d = cnt_in_q + CIN_W'(1);
          end
        end
      end
      IN_WAIT: begin
        if (w_clear_end) in_st_d = w_run_next ? IN_PASS : IN_IDLE;
      end
      default: in_st_d = IN_IDLE;
    endcase

    case (out_st_q)
      OUT_IDLE: begin
        if (w_start_ok) begin
          out_st_d  = OUT_PASS;
          cnt_out_d = '0;
        end
      end
      OUT_PASS: begin
        if (w_timeout_hit) begin
          out_st_d  = OUT_CLEAR;
          cnt_out_d = '0;
        end else if (w_out_beat) begin
          if (cnt_out_q == OUT_LAST) begin
            out_st_d  = OUT_CLEAR;
            cnt_out_d = '0;
          end else begin
            cnt_out_d = cnt_out_q + COUT_W'(1);
          end
        end
      end
      OUT_CLEAR: begin
        if (w_clear_end) begin
          out_st_d  = w_run_next ? OUT_PASS : OUT_IDLE;
          cnt_out_d = '0;
          if (w_count_frame) frames_d = frames_q + FRAME_CNT_W'(1);
        end else begin
          cnt_out_d = cnt_out_q + COUT_W'(1);
        end
      end
      default: out_st_d = OUT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_st_q   <= IN_IDLE;
      out_st_q  <= OUT_IDLE;
      cnt_in_q  <= '0;
      cnt_out_q <= '0;
      stop_q    <= 1'b0;
      frames_q  <= '0;
      tot_in_q  <= '0;
      tot_out_q <= '0;
    end else begin
      in_st_q   <= in_st_d;
      out_st_q  <= out_st_d;
      cnt_in_q  <= cnt_in_d;
      cnt_out_q <= cnt_out_d;
      stop_q    <= stop_d;
      frames_q  <= frames_d;
      tot_in_q  <= tot_in_d;
      tot_out_q <= tot_out_d;
    end
  end

`ifdef FRAME_GATE_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYC - 1);

  logic [STALL_W-1:0] stall_q, stall_d;
  logic               err_q, err_d, tof_q, tof_d;

  // Stall only accumulates while the sink is willing but the pipe is silent.
  assign w_timeout_hit = w_out_pass && out_ready && !w_out_beat && (stall_q == STALL_LAST);
  assign w_count_frame = !tof_q;
  assign err_timeout   = err_q;

  always_comb begin
    stall_d = stall_q;
    if (!w_out_pass || w_out_beat || w_timeout_hit) stall_d = '0;
    else if (out_ready)                             stall_d = stall_q + STALL_W'(1);
    err_d = err_q || w_timeout_hit;
    tof_d = w_timeout_hit ? 1'b1 : (w_clear_end ? 1'b0 : tof_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      err_q   <= 1'b0;
      tof_q   <= 1'b0;
    end else begin
      stall_q <= stall_d;
      err_q   <= err_d;
      tof_q   <= tof_d;
    end
  end
`else
  localparam int c_unused_timeout_cyc = TIMEOUT_CYC;
  assign w_timeout_hit = 1'b0;
  assign w_count_frame = 1'b1;
  assign err_timeout   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_frame_gate_wrap.sv
`default_nettype none
// Randomized bench for frame_gate_wrap: pipeline stub, frame-level reference
// model and an output-data scoreboard.
module tb_frame_gate_wrap;
  localparam int IN_W = 64, OUT_W = 64, IN_BEATS = 8, OUT_BEATS = 32;
  localparam int CLEAR_CYCLES = 4, FCW = 8, TIMEOUT_CYC = 16;
  localparam int RATIO = OUT_BEATS / IN_BEATS;
`ifdef FRAME_GATE_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0, cfg_continuous = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0, pipe_in_ready = 1'b0, pipe_out_valid = 1'b0;
  logic [IN_W-1:0]  in_data = '0;
  logic [OUT_W-1:0] pipe_out_data = '0;
  logic in_ready, out_valid, pipe_in_valid, pipe_out_ready, pipe_reset, busy, frame_done, err_timeout;
  logic [OUT_W-1:0] out_data;
  logic [IN_W-1:0]  pipe_in_data;
  logic [FCW-1:0]   frames_done;
  logic [31:0]      tot_in, tot_out;

  frame_gate_wrap #(
    .IN_W(IN_W), .OUT_W(OUT_W), .IN_BEATS(IN_BEATS), .OUT_BEATS(OUT_BEATS),
    .CLEAR_CYCLES(CLEAR_CYCLES), .FRAME_CNT_W(FCW), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .cfg_continuous(cfg_continuous),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .pipe_in_valid(pipe_in_valid), .pipe_in_ready(pipe_in_ready), .pipe_in_data(pipe_in_data),
    .pipe_out_valid(pipe_out_valid), .pipe_out_ready(pipe_out_ready), .pipe_out_data(pipe_out_data),
    .pipe_reset(pipe_reset), .busy(busy), .frame_done(frame_done), .frames_done(frames_done),
    .tot_in(tot_in), .tot_out(tot_out), .err_timeout(err_timeout)
  );

  initial forever #5 clk = ~clk;

  int checks = 0, failures = 0;
  int p_iv = 100, p_or = 100, p_pir = 100, p_pov = 100;
  logic [OUT_W-1:0] pq[$];
  logic [OUT_W-1:0] exq[$];
  int ob_frame = 0;

  function automatic logic [OUT_W-1:0] xf(logic [IN_W-1:0] w, int k);
    return {w[31:0], w[63:32]} + 64'(k);
  endfunction

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit rnd(int pct);
    return int'($urandom_range(99)) < pct;
  endfunction

  // Stimulus drive, just after each rising edge.
  always begin
    @(posedge clk); #1;
    in_valid       = rnd(p_iv);
    in_data        = {$urandom, $urandom};
    out_ready      = rnd(p_or);
    pipe_in_ready  = rnd(p_pir);
    pipe_out_valid = (pq.size() > 0) && rnd(p_pov);
    pipe_out_data  = (pq.size() > 0) ? pq[0] : 64'hDEAD_BEEF_0BAD_F00D;
  end

  // External pipeline stub: each accepted input word yields RATIO output words.
  always @(negedge clk) begin
    if (pipe_reset) pq.delete();
    else begin
      if (pipe_out_valid && pipe_out_ready) void'(pq.pop_front());
      if (pipe_in_valid && pipe_in_ready)
        for (int k = 0; k < RATIO; k++) pq.push_back(xf(pipe_in_data, k));
    end
  end

  // Expected output words pushed as upstream beats are accepted.
  always @(negedge clk) begin
    if (reset) exq.delete();
    else if (in_valid && in_ready)
      for (int k = 0; k < RATIO; k++) exq.push_back(xf(in_data, k));
  end

  // Output monitor: pops and compares on every downstream handshake.
  always @(negedge clk) begin
    if (reset) ob_frame = 0;
    else begin
      if (out_valid && out_ready) begin
        ob_frame++;
        if (exq.size() == 0) begin
          checks++; failures++;
          $display("FAIL sb_underflow actual=%0h required=<none>", out_data);
        end else chk("out_data", out_data, exq.pop_front());
      end
      if (frame_done) begin
        if (!err_timeout) chk("sb_drained", 128'(exq.size()), 0);
        exq.delete();
        ob_frame = 0;
      end
    end
  end

  // Frame-level reference model, expressed as beat/clear counts per frame.
  bit armed = 0, m_run = 0, m_stop = 0, m_err = 0, m_tof = 0;
  int m_in = 0, m_out = 0, m_clr = -1, m_stall = 0;
  logic [FCW-1:0] m_frames = '0;
  logic [31:0] m_tin = '0, m_tout = '0;
  bit in_open, out_pass, clearing, exp_fd, hs_in, hs_out, drain, go, was_run;

  always @(negedge clk) begin
    in_open  = m_run && (m_in < IN_BEATS);
    out_pass = m_run && (m_clr < 0);
    clearing = m_run && (m_clr >= 0);
    exp_fd   = clearing && (m_clr == CLEAR_CYCLES - 1);
    if (armed) begin
      chk("ctrl", {in_ready, pipe_in_valid, out_valid, pipe_out_ready, pipe_reset, busy, frame_done, err_timeout},
          {in_open && pipe_in_ready, in_open && in_valid, out_pass && pipe_out_valid,
           out_pass ? out_ready : clearing, !out_pass, m_run, exp_fd, m_err});
      chk("counters", {frames_done, tot_in, tot_out}, {m_frames, m_tin, m_tout});
      chk("data_pass", {pipe_in_data, out_data}, {in_data, pipe_out_data});
    end
    if (reset) begin
      m_run = 0; m_in = 0; m_out = 0; m_clr = -1; m_stop = 0; m_err = 0; m_tof = 0; m_stall = 0;
      m_frames = '0; m_tin = '0; m_tout = '0; armed = 1;
    end else begin
      hs_in   = in_open && in_valid && pipe_in_ready;
      hs_out  = out_pass && pipe_out_valid && out_ready;
      drain   = clearing && pipe_out_valid;
      go      = cfg_continuous && !(m_stop || stop);
      was_run = m_run;
      if (hs_in) m_tin++;
      if (hs_out || drain) m_tout++;
      if (!m_run) begin
        if (start) begin m_run = 1; m_in = 0; m_out = 0; m_clr = -1; m_stall = 0; m_tof = 0; end
      end else begin
        if (hs_in) m_in++;
        if (out_pass) begin
          if (hs_out) begin
            m_out++; m_stall = 0;
            if (m_out == OUT_BEATS) m_clr = 0;
          end else if (out_ready && TIMEOUT_ON) begin
            m_stall++;
            if (m_stall == TIMEOUT_CYC) begin m_clr = 0; m_in = IN_BEATS; m_err = 1; m_tof = 1; end
          end
        end else if (m_clr == CLEAR_CYCLES - 1) begin
          if (!m_tof) m_frames++;
          if (go) begin m_in = 0; m_out = 0; m_clr = -1; m_stall = 0; m_tof = 0; end
          else m_run = 0;
        end else m_clr++;
      end
      m_stop = stop ? 1'b1 : (was_run ? m_stop : 1'b0);
    end
  end

  task automatic do_reset();
    @(posedge clk); #1; reset = 1;
    repeat (2) @(posedge clk);
    #1; reset = 0;
  endtask

  task automatic pulse_start(bit with_stop);
    @(posedge clk); #1; start = 1; stop = with_stop;
    @(posedge clk); #1; start = 0; stop = 0;
  endtask

  task automatic wait_idle(string nm, int budget);
    int n = 0;
    @(negedge clk);
    while (busy && n < budget) begin @(negedge clk); n++; end
    chk({nm, "_idle"}, 128'(busy), 0);
  endtask

  task automatic wait_frames(int nf, int budget);
    int n = 0;
    @(negedge clk);
    while (int'(frames_done) < nf && n < budget) begin @(negedge clk); n++; end
    chk("wait_frames", 128'(frames_done), 128'(nf));
  endtask

  initial begin
    #600000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    do_reset();
    @(negedge clk);
    chk("rst_busy", 128'(busy), 0);
    chk("rst_pipe_reset", 128'(pipe_reset), 1);
    chk("rst_frames", 128'(frames_done), 0);

    // Single frame at full rate.
    pulse_start(0);
    wait_idle("t1", 2000);
    chk("t1_frames", 128'(frames_done), 1);
    chk("t1_tot_in", 128'(tot_in), 8);
    chk("t1_tot_out", 128'(tot_out), 32);

    // Three continuous frames with random throttling.
    do_reset();
    p_iv = 60; p_or = 55; p_pir = 70; p_pov = 65;
    cfg_continuous = 1;
    pulse_start(0);
    wait_frames(2, 4000);
    @(posedge clk); #1; cfg_continuous = 0;
    wait_idle("t2", 4000);
    chk("t2_frames", 128'(frames_done), 3);
    chk("t2_tot_in", 128'(tot_in), 24);
    chk("t2_tot_out", 128'(tot_out), 96);

    // Graceful stop mid-frame 2, then a clean restart.
    do_reset();
    cfg_continuous = 1;
    pulse_start(0);
    wait_frames(1, 4000);
    n = 0;
    while (ob_frame < 10 && n < 4000) begin @(negedge clk); n++; end
    chk("t3_beat10", 128'(ob_frame >= 10), 1);
    @(posedge clk); #1; stop = 1;
    @(posedge clk); #1; stop = 0;
    wait_idle("t3", 4000);
    chk("t3_frames", 128'(frames_done), 2);
    cfg_continuous = 0;
    pulse_start(0);
    wait_idle("t3b", 4000);
    chk("t3_restart", 128'(frames_done), 3);

    // Reset in the middle of a frame.
    do_reset();
    pulse_start(0);
    n = 0;
    @(negedge clk);
    while (tot_in < 5 && n < 2000) begin @(negedge clk); n++; end
    chk("t4_beat5", 128'(tot_in >= 5), 1);
    @(posedge clk); #1; reset = 1;
    @(posedge clk); #1; reset = 0;
    @(negedge clk);
    chk("t4_state", {busy, pipe_reset, in_ready, out_valid}, 4'b0100);
    chk("t4_counts", {frames_done, tot_in, tot_out}, 0);

    // Start while busy is ignored; start+stop runs exactly one frame.
    do_reset();
    pulse_start(0);
    repeat (5) @(posedge clk);
    pulse_start(0);
    wait_idle("t5a", 4000);
    chk("t5_ignored", 128'(frames_done), 1);
    cfg_continuous = 1;
    pulse_start(1);
    wait_idle("t5b", 4000);
    chk("t5_one_frame", 128'(frames_done), 2);
    cfg_continuous = 0;

`ifdef FRAME_GATE_TIMEOUT_EN
    // Output stall watchdog.
    do_reset();
    p_pov = 0; p_or = 100;
    pulse_start(0);
    wait_idle("t6", 2000);
    chk("t6_err", 128'(err_timeout), 1);
    chk("t6_frames", 128'(frames_done), 0);
    p_pov = 65;
`endif

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
